// File: rtl/iter_sched_pkg.sv
// iter_sched_pkg: shared constants for the iterative-unit scheduler.
//   - default values for N, MAX_CYC and CNT_W
//   - FSM state encodings (kept as plain 2-bit constants)
//   - idx_w(): width needed to hold an index/count in [0, n-1]
package iter_sched_pkg;

  localparam int unsigned N_DEF       = 4;
  localparam int unsigned MAX_CYC_DEF = 16;
  localparam int unsigned CNT_W_DEF   = 5;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'b00;
  localparam state_t START = 2'b01;
  localparam state_t WAIT  = 2'b10;
  localparam state_t FIN   = 2'b11;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iter_sched_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req        - N request lines
//   last_owner - index of the previous owner; search starts just after it
//   winner     - one-hot winner, all zero when req is zero
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned LW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last_owner,
  output logic [N-1:0]  winner
);

  logic [LW:0]    first;
  logic [2*N-1:0] dbl_req;
  logic [N-1:0]   rot;
  logic [N-1:0]   pick;
  logic [2*N-1:0] dbl_pick;

  // Rotate so that index last_owner+1 lands at bit 0, isolate the lowest
  // set bit, then rotate back. Doubling the vector turns both rotations
  // into plain shifts; first never exceeds N.
  always_comb begin
    first    = {1'b0, last_owner} + 1'b1;
    dbl_req  = {req, req} >> first;
    rot      = dbl_req[N-1:0];
    pick     = rot & (~rot + 1'b1);
    dbl_pick = {pick, pick} << first;
    winner   = dbl_pick[2*N-1:N];
  end

endmodule

// File: rtl/iter_sched.sv
// iter_sched: grants one shared iterative unit to N requesters in
// round-robin order and supervises each operation with a watchdog.
//   clk, rst_n    - clock, asynchronous active-low reset
//   req[N]        - level requests, held until done/err
//   unit_do_iter  - unit performs an iteration this cycle
//   unit_ready    - unit finished the operation (1-cycle)
//   unit_start    - 1-cycle start pulse to the unit
//   gnt[N]        - one-hot owner of the unit, stable START..FIN
//   done[N]/err[N]- 1-cycle completion / watchdog pulse to the owner
//   busy          - FSM not idle
//   iter_cnt      - saturating iteration count of the last operation
module iter_sched
  import iter_sched_pkg::*;
#(
  parameter int unsigned N       = N_DEF,
  parameter int unsigned MAX_CYC = MAX_CYC_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             unit_do_iter,
  input  logic             unit_ready,
  output logic             unit_start,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     done,
  output logic [N-1:0]     err,
  output logic             busy,
  output logic [CNT_W-1:0] iter_cnt
);

  localparam int unsigned      LW        = idx_w(N);
  localparam int unsigned      CYC_W     = idx_w(MAX_CYC);
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(MAX_CYC - 1);
  localparam logic [LW-1:0]    OWNER_RST = LW'(N - 1);

  state_t           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             ok_q, ok_d;
  logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [LW-1:0]    last_owner_q, last_owner_d;

  logic [N-1:0]     winner;
  logic [LW-1:0]    owner_idx;

  rr_pick #(
    .N  (N),
    .LW (LW)
  ) u_rr_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .winner     (winner)
  );

  always_comb begin
    owner_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_q[i]) owner_idx = LW'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    ok_d         = ok_q;
    iter_cnt_d   = iter_cnt_q;
    cyc_d        = cyc_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          gnt_d   = winner;
          state_d = START;
        end
      end
      START: begin
        cyc_d      = '0;
        iter_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (unit_do_iter && (iter_cnt_q != '1)) iter_cnt_d = iter_cnt_q + 1'b1;
        // unit_ready is tested first so it wins a tie with the watchdog
        if (unit_ready) begin
          ok_d    = 1'b1;
          state_d = FIN;
        end else if (cyc_q == CYC_LAST) begin
          ok_d    = 1'b0;
          state_d = FIN;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      FIN: begin
        last_owner_d = owner_idx;
        gnt_d        = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      ok_q         <= 1'b0;
      iter_cnt_q   <= '0;
      cyc_q        <= '0;
      last_owner_q <= OWNER_RST;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      ok_q         <= ok_d;
      iter_cnt_q   <= iter_cnt_d;
      cyc_q        <= cyc_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Every output is a decode of registered state only.
  assign unit_start = (state_q == START);
  assign busy       = (state_q != IDLE);
  assign gnt        = gnt_q;
  assign done       = ((state_q == FIN) && ok_q)  ? gnt_q : '0;
  assign err        = ((state_q == FIN) && !ok_q) ? gnt_q : '0;
  assign iter_cnt   = iter_cnt_q;

endmodule

// File: doc/iter_sched.md
ITER_SCHED -- requirements
Module: iter_sched

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters sharing one iterative unit.
REQ-002 SHALL have parameter MAX_CYC, default 16: watchdog limit, in cycles, spent waiting for the unit.
REQ-003 SHALL have parameter CNT_W, default 5: width of the iteration counter.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  N  per-requester operation request; level, held until done or err.
REQ-007 unit_do_iter  input  1  unit is performing an iteration this cycle.
REQ-008 unit_ready  input  1  unit reports operation finished; 1-cycle level.
REQ-009 unit_start  output  1  start pulse to the unit.
REQ-010 gnt  output  N  one-hot grant; selects the owner of the unit's operands and result.
REQ-011 done  output  N  1-cycle pulse to the owner on normal completion.
REQ-012 err  output  N  1-cycle pulse to the owner on watchdog expiry.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 iter_cnt  output  CNT_W  iteration count of the last completed or aborted operation.

Function
REQ-015 SHALL be a 4-state FSM (IDLE, START, WAIT, FIN); all outputs decode from registers only.
REQ-016 IDLE: if req!=0 at an edge, SHALL load gnt with the round-robin winner and go to START; otherwise stay in IDLE.
REQ-017 Round-robin: search starts at index (last_owner+1) mod N and wraps; after reset last_owner=N-1, so req[0] has first priority.
REQ-018 START: unit_start=1 for exactly this one cycle; cycle counter and iter_cnt SHALL clear; next state is WAIT.
REQ-019 WAIT: iter_cnt increments on each cycle with unit_do_iter=1 and saturates at 2^CNT_W-1; the cycle counter increments every cycle.
REQ-020 WAIT exit: unit_ready=1 -> FIN with flag ok; else cycle counter == MAX_CYC-1 -> FIN with flag timeout.
REQ-021 If unit_ready and the watchdog limit coincide, unit_ready SHALL win (ok).
REQ-022 FIN: done=gnt if ok, err=gnt if timeout, for one cycle.
REQ-023 FIN: SHALL update last_owner to the granted index, clear gnt on leaving, and go to IDLE.
REQ-024 gnt SHALL be stable from the edge entering START through the last cycle of FIN.
REQ-025 Deassertion of req by the owner mid-operation SHALL be ignored; the operation completes normally.
REQ-026 New req changes during START, WAIT or FIN SHALL be ignored until IDLE.
REQ-027 Minimum turnaround: req seen at edge k -> unit_start high in cycle k+1 -> earliest done at cycle k+3.
REQ-028 IDLE always lasts at least 1 cycle between operations; an owner still requesting competes again under round-robin.
REQ-029 iter_cnt SHALL hold its value from FIN until the next START.
REQ-030 unit_ready or unit_do_iter outside WAIT SHALL be ignored.

Reset
REQ-031 On rst_n=0 asynchronously: state=IDLE, gnt=0, done=0, err=0, unit_start=0, busy=0, iter_cnt=0, last_owner=N-1, cycle counter=0.
REQ-032 Reset asserted mid-operation SHALL abort silently: no done or err pulse is issued.

Structure
REQ-033 Package iter_sched_pkg SHALL hold the state encodings (IDLE=2'b00, START=2'b01, WAIT=2'b10, FIN=2'b11) and the default N, MAX_CYC and CNT_W.
REQ-034 Round-robin selection SHALL be one combinational sub-module, rr_pick (inputs req and last_owner; output one-hot winner).

Verification
REQ-035 Single request: req=4'b0001, unit_ready 5 cycles after unit_start -> gnt=0001, done[0] pulse, iter_cnt equals the number of do_iter cycles.
REQ-036 Fairness: req=4'b1111 held for 8 operations -> grant order 0,1,2,3,0,1,2,3.
REQ-037 Watchdog: unit_ready never asserted -> err pulse on the owner exactly MAX_CYC cycles after WAIT entry; done stays 0.
REQ-038 Tie: unit_ready asserted in the same cycle the watchdog reaches MAX_CYC-1 -> done, no err.
REQ-039 Reset mid-WAIT -> all outputs 0 immediately; the next req=4'b0100 is granted with priority restarting at index 0.
REQ-040 Saturation: 40 do_iter cycles with CNT_W=5 and MAX_CYC=64 -> iter_cnt=31.
